// File: rtl/send_sched_pkg.sv
// Shared types for the round-robin send scheduler: state encoding, channel
// index type and the round-robin pick helper.
package send_sched_pkg;

    localparam int unsigned MaxCh = 16;
    localparam int unsigned IdxW  = 4;

    typedef logic [IdxW-1:0] ch_idx_t;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    // First set bit of req searching upward from last+1, wrapping at num_ch.
    function automatic ch_idx_t rr_pick(input logic [MaxCh-1:0] req,
                                        input ch_idx_t          last,
                                        input logic [IdxW:0]    num_ch);
        logic [IdxW:0] idx;
        logic          found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= MaxCh; k++) begin
            idx = {1'b0, last} + (IdxW+1)'(k);
            if (idx >= num_ch) begin
                idx = idx - num_ch;
            end
            if (!found && ((IdxW+1)'(k) <= num_ch) && req[idx[IdxW-1:0]]) begin
                rr_pick = idx[IdxW-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/pend_cnt.sv
// One channel's pending-send counter: saturating up/down with a sticky
// overflow flag raised when an increment is dropped at saturation.
module pend_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero,
    output logic             overflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (inc && !dec) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt      = cnt_q;
    assign nonzero  = |cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/send_sched_rr.sv
// Round-robin send scheduler: queues per-channel data-ready pulses and grants
// one channel at a time to the shared sender, rotating after BURST transfers.
module send_sched_rr
    import send_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned BURST  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] up_next,
    input  logic              send_done,
    output logic              send_req,
    output logic [NUM_CH-1:0] sending,
    output logic              pending_any,
    output logic [NUM_CH-1:0] overflow
);

    localparam int unsigned BW = $clog2(BURST + 1);

    state_e           state_q, state_d;
    ch_idx_t          grant_q, grant_d;
    ch_idx_t          last_q, last_d;
    logic [BW-1:0]    burst_q, burst_d;

    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0] nonzero;
    logic [NUM_CH-1:0] last_one;
    logic [NUM_CH-1:0] dec;
    logic [NUM_CH-1:0] eligible;
    logic [MaxCh-1:0]  req_vec;
    logic              burst_end;
    logic              drained;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_cnt
        pend_cnt #(
            .CNT_W(CNT_W)
        ) u_pend_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (up_next[g]),
            .dec     (dec[g]),
            .cnt     (cnt[g]),
            .nonzero (nonzero[g]),
            .overflow(overflow[g])
        );
        // Granted counter reaches zero this cycle unless a same-cycle increment offsets it.
        assign last_one[g] = (cnt[g] == CNT_W'(1)) && !up_next[g];
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sending[i] = (state_q == StSend) && (grant_q == ch_idx_t'(i));
        end
    end

    assign dec      = {NUM_CH{send_done}} & sending;
    assign eligible = nonzero | up_next;

    always_comb begin
        req_vec               = '0;
        req_vec[NUM_CH-1:0]   = eligible;
    end

    assign drained   = |(last_one & sending);
    assign burst_end = ({1'b0, burst_q} + 1'b1) == (BW+1)'(BURST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    grant_d = rr_pick(req_vec, last_q, (IdxW+1)'(NUM_CH));
                    burst_d = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (send_done) begin
                    burst_d = burst_q + 1'b1;
                    if (drained || burst_end) begin
                        state_d = StIdle;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= ch_idx_t'(NUM_CH - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    assign send_req    = (state_q == StSend);
    assign pending_any = |nonzero;

endmodule

// File: doc/send_sched_rr.md
# send_sched_rr

Parametrised send scheduler for the multi-dataflow median filter output stage. It accepts "data ready" pulses from `NUM_CH` upstream channels and queues them in per-channel pending counters. It grants one channel at a time to a shared downstream sender using round-robin arbitration, and holds the request until the sender returns `send_done`. A channel may keep the grant for up to `BURST` transfers before the scheduler rotates to the next channel. This generalises the single-channel IDLE/SEND send FSM to N queued channels with fairness and overflow reporting.

## Interface
- `NUM_CH`, default 4: number of upstream channels (at least 2).
- `CNT_W`, default 4: width of each pending counter; a channel saturates at 2^CNT_W-1 pending sends.
- `BURST`, default 2: maximum consecutive `send_done` pulses served per grant (at least 1).
- Reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `up_next`  in  NUM_CH  per-channel single-cycle pulse; each high cycle adds one pending send.
- `send_done`  in  1  downstream pulse; the current transfer is complete.
- `send_req`  out  1  request to the sender; high throughout SEND.
- `sending`  out  NUM_CH  one-hot granted channel during SEND; zero in IDLE.
- `pending_any`  out  1  OR of all counters being nonzero (registered state only).
- `overflow`  out  NUM_CH  sticky per-channel flag: an `up_next` arrived while the counter was saturated.

## Operation
- **Counters:** `cnt[i]` next value is `cnt[i]` + `up_next[i]` − (`send_done` & `sending[i]`).
  - Increment and decrement in the same cycle leave the counter unchanged.
  - At saturation an increment is dropped and `overflow[i]` is set; the flag clears only on reset.
  - Decrement at zero cannot occur, because a grant requires a pending send.
- **State machine** (2 states, IDLE and SEND):
  - **IDLE:** channel i is eligible when `cnt[i]`!=0 or `up_next[i]`=1, so a same-cycle request bypasses the counter.
    - If any channel is eligible, pick the first eligible channel searching from `last+1` modulo NUM_CH. Register it as the grant, set `burst_cnt`=0 and go to SEND.
    - Otherwise stay in IDLE.
    - `send_done` received in IDLE is ignored; no counter changes.
  - **SEND:** on each `send_done`, `burst_cnt` increments.
    - Go to IDLE when the granted counter's next value is 0, or when `burst_cnt`+1 == BURST.
    - Otherwise stay in SEND with the same grant.
    - On leaving SEND, `last` takes the granted index.
- **Rotation and fairness:**
  - Every grant ends with at least one IDLE cycle, so `send_req` falls for at least one cycle between grants, as the downstream handshake requires.
  - A continuously requesting channel is starved for at most (NUM_CH−1) grants.
- **Derived outputs:** `send_req` = (state==SEND). `sending` = grant one-hot gated by SEND.

## Timing
- **Reset values:**
  - state IDLE; all counters 0; `last` = NUM_CH−1, so channel 0 wins the first arbitration.
  - `send_req`=0, `sending`=0, `pending_any`=0, `overflow`=0.
- **Request latency:** `up_next[i]` at cycle t with scheduler in IDLE gives `send_req`=1 and `sending[i]`=1 from cycle t+1. This is the same one-cycle latency as the single-channel FSM.
- **Release latency:** a terminating `send_done` at cycle t gives `send_req`=0 at cycle t+1. The earliest next grant is at t+2.
- **Registered outputs:** all outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.
- **Reset mid-SEND:** immediate return to IDLE. Queued counts and overflow flags are discarded. `send_req` drops asynchronously.

## Structure
- **Package `send_sched_pkg`:** state encoding constants (IDLE=0, SEND=1) and a round-robin helper function returning the next eligible index from a request vector and a `last` index.
- **Sub-module `pend_cnt`:** one saturating up/down counter with its sticky overflow flag. It is instantiated NUM_CH times by a generate loop.
- **Top level:** FSM, arbiter, burst counter and the `last` register live in the top level.

## Test plan
- **Single request:** `up_next`=4'b0001 for one cycle from reset → `send_req` and `sending`=0001 next cycle; one `send_done` → IDLE next cycle, `cnt[0]`=0.
- **Round-robin:** `up_next`=1111 in one cycle, then `send_done` every 3rd cycle → grant order 0,1,2,3; exactly one IDLE cycle between grants.
- **Burst limit:** BURST=2, five `up_next[2]` pulses → grants to channel 2 of 2, 2 and 1 transfers; `cnt[2]` ends at 0.
- **Burst rotation:** BURST=2 with `cnt[1]`=3 and `cnt[3]`=1 → grant order 1(×2), 3(×1), 1(×1).
- **Simultaneous increment/decrement:** `up_next[g]` and `send_done` in the same cycle on the granted channel → counter unchanged, grant held until the burst limit.
- **Overflow:** CNT_W=2 with 4 `up_next[0]` pulses and no `send_done` → `cnt[0]`=3, `overflow[0]`=1 and sticky through later sends.
- **Reset mid-SEND:** assert `rst_n`=0 while `cnt[0]`=2 → all outputs 0 immediately; after release, no request is issued without a new `up_next`.
